piso_bit_tx: RTL and testbench

- Parallel-in serial-out bit transmitter.
- Loads a WIDTH-bit word on a start request and presents it one bit at a time on sout.
- Each bit is held for DIV clock cycles. A one-cycle sen strobe marks when a downstream enable-flop / shift-register receiver must capture the bit.
- Sits on the transmit side of the team's serial bit-link, opposite the enable-gated capture registers.

---
 rtl/piso_bit_tx.sv | 97 +++++++++
 tb/tb_piso_bit_tx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_bit_tx.sv
// Parallel-in serial-out bit transmitter: shifts a WIDTH-bit word out on sout,
// holding each bit DIV cycles and strobing sen on the last cycle of each bit.
module piso_bit_tx #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic             sen,
  output logic             busy,
  output logic             done
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [TW-1:0]    tick_cnt;
  logic [BW-1:0]    bit_cnt;
  logic             tick_last;

  // Advance the word by one bit position towards the output end, zero fill.
  function automatic logic [WIDTH-1:0] shift_next(input logic [WIDTH-1:0] v);
    if (LSB_FIRST != 0)
      return {1'b0, v[WIDTH-1:1]};
    else
      return {v[WIDTH-2:0], 1'b0};
  endfunction

  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    if (LSB_FIRST != 0)
      return v[0];
    else
      return v[WIDTH-1];
  endfunction

  assign tick_last = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg    <= din;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick_last) begin
            tick_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              state <= DONE;
            end else begin
              shreg   <= shift_next(shreg);
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode only registered state, so reset clears them without a clock edge.
  assign busy = (state == SHIFT);
  assign done = (state == DONE);
  assign sout = busy & head_bit(shreg);
  assign sen  = busy & tick_last;

endmodule

// File: tb/tb_piso_bit_tx.sv
// Scoreboard bench for piso_bit_tx: three instances (LSB/DIV4, MSB/DIV4, LSB/DIV1)
// with a cycle-accurate reference monitor and a SIPO loopback model.
module tb_piso_bit_tx;

  logic       clk;
  logic       reset;
  logic [2:0] start;
  logic [7:0] din [3];
  logic [2:0] sout, sen, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  piso_bit_tx #(.WIDTH(8), .DIV(4), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .reset(reset), .start(start[0]), .din(din[0]),
    .sout(sout[0]), .sen(sen[0]), .busy(busy[0]), .done(done[0]));

  piso_bit_tx #(.WIDTH(8), .DIV(4), .LSB_FIRST(0)) u_msb (
    .clk(clk), .reset(reset), .start(start[1]), .din(din[1]),
    .sout(sout[1]), .sen(sen[1]), .busy(busy[1]), .done(done[1]));

  piso_bit_tx #(.WIDTH(8), .DIV(1), .LSB_FIRST(1)) u_div1 (
    .clk(clk), .reset(reset), .start(start[2]), .din(din[2]),
    .sout(sout[2]), .sen(sen[2]), .busy(busy[2]), .done(done[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int         c0;
    logic [7:0] w;
    bit         lsb;
  } xfer_t;

  xfer_t lq[$];
  int    gcyc = 0;
  int    sel  = 0;
  bit    active = 0;

  always @(posedge clk) gcyc <= gcyc + 1;

  // Reference monitor for the selected instance
  xfer_t      cur;
  int         t, nb, div_m, bi;
  logic [7:0] rec;
  logic       exp_bit, sout_m, sen_m, busy_m, done_m;

  always @(negedge clk) begin
    div_m  = (sel == 2) ? 1 : 4;
    sout_m = sout[sel];
    sen_m  = sen[sel];
    busy_m = busy[sel];
    done_m = done[sel];
    if (reset) begin
      active = 0;
    end else begin
      if (!active && lq.size() > 0 && lq[0].c0 == gcyc) begin
        cur    = lq.pop_front();
        active = 1;
        t      = 0;
        nb     = 0;
        rec    = 8'h00;
      end
      if (active) begin
        if (t < 8 * div_m) begin
          bi      = t / div_m;
          exp_bit = cur.lsb ? cur.w[bi] : cur.w[7-bi];
          check("busy", {31'd0, busy_m}, 1);
          check("done_early", {31'd0, done_m}, 0);
          check("sout", {31'd0, sout_m}, {31'd0, exp_bit});
          check("sen", {31'd0, sen_m}, {31'd0, (t % div_m) == div_m - 1});
          if (sen_m && nb < 8) begin
            if (cur.lsb) rec[nb] = sout_m;
            else         rec = {rec[6:0], sout_m};
            nb++;
          end
        end else begin
          check("done", {31'd0, done_m}, 1);
          check("busy_at_done", {31'd0, busy_m}, 0);
          check("sen_at_done", {31'd0, sen_m}, 0);
          check("sout_at_done", {31'd0, sout_m}, 0);
          check("nbits", nb, 8);
          check("loopback", {24'd0, rec}, {24'd0, cur.w});
          active = 0;
        end
        t++;
      end else begin
        check("idle_outs", {28'd0, sout_m, sen_m, busy_m, done_m}, 0);
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while ((lq.size() != 0 || active) && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", {31'd0, k < 400}, 1);
  endtask

  task automatic launch(input int s, input logic [7:0] w);
    @(negedge clk);
    din[s]   = w;
    start[s] = 1'b1;
    lq.push_back('{c0: gcyc + 1, w: w, lsb: (s != 1)});
    @(negedge clk);
    start[s] = 1'b0;
  endtask

  initial begin
    int g;
    start = 3'b000;
    for (int i = 0; i < 3; i++) din[i] = 8'h00;
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_outs_lsb", {28'd0, sout[0], sen[0], busy[0], done[0]}, 0);
    check("rst_outs_msb", {28'd0, sout[1], sen[1], busy[1], done[1]}, 0);
    check("rst_outs_div1", {28'd0, sout[2], sen[2], busy[2], done[2]}, 0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;

    // LSB-first basic
    sel = 0;
    launch(0, 8'hA5);
    wait_idle();

    // MSB-first
    sel = 1;
    launch(1, 8'hA5);
    wait_idle();
    launch(1, 8'h3C);
    wait_idle();

    // DIV=1 corner
    sel = 2;
    launch(2, 8'h81);
    wait_idle();

    // Start pulses during SHIFT and DONE must be ignored
    sel = 0;
    launch(0, 8'h96);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      start[0] = (k == 3 || k == 20 || k == 32);
      din[0]   = 8'($urandom);
    end
    @(negedge clk);
    start[0] = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);

    // Start held high: relaunch after one idle cycle; din change mid-transfer
    @(negedge clk);
    g = gcyc;
    din[0]   = 8'hFF;
    start[0] = 1'b1;
    lq.push_back('{c0: g + 1, w: 8'hFF, lsb: 1'b1});
    lq.push_back('{c0: g + 1 + 34, w: 8'h00, lsb: 1'b1});
    repeat (11) @(negedge clk);
    din[0] = 8'h00;
    repeat (30) @(negedge clk);
    start[0] = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);

    // Asynchronous reset in cycle 13 of a transfer
    launch(0, 8'h5A);
    repeat (13) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy[0]}, 1);
    #2 reset = 1'b1;
    #1;
    check("midrst_outs", {28'd0, sout[0], sen[0], busy[0], done[0]}, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (40) begin
      @(negedge clk);
      check("no_done_after_rst", {31'd0, done[0]}, 0);
    end
    launch(0, 8'hC3);
    wait_idle();

    // Random loopback
    for (int n = 0; n < 50; n++) begin
      launch(0, 8'($urandom));
      wait_idle();
    end
    sel = 1;
    for (int n = 0; n < 6; n++) begin
      launch(1, 8'($urandom));
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
